fpmult_arbiter: RTL and testbench
=================================

FPMULT_ARBITER -- requirements
Module: fpmult_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the doneFP watchdog limit in clock cycles; it is used only when FPMULT_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  requester N holds high with operands stable until its doneN pulse.
REQ-005 a0, b0, a1, b1  input  32 each  IEEE-754 single-precision operands A and B of requester N.
REQ-006 done0, done1  output  1 each  one-cycle pulse: requester N's result is valid.
REQ-007 res0, res1  output  32 each  product for requester N, held until that requester's next done pulse.
REQ-008 err0, err1  output  1 each  high with doneN when the operation timed out.
REQ-009 startFP  output  1  start pulse to the shared multiplier.
REQ-010 inBus  output  32  serial operand bus to the multiplier.
REQ-011 resBus  input  32  multiplier result, valid while doneFP is high.
REQ-012 doneFP  input  1  multiplier completion strobe.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states and transitions: IDLE, START, LOADA, LOADB, WAIT, RESP; IDLE->START on any req, START->LOADA->LOADB->WAIT unconditionally, WAIT->RESP on doneFP, RESP->IDLE unconditionally.
REQ-015 Arbitration in IDLE only: single request wins; simultaneous requests go to the requester not served last; after reset requester 0 wins a tie; grant latched until RESP exits.
REQ-016 startFP is high exactly for the one START cycle and low in all other states.
REQ-017 inBus = granted A during LOADA, granted B during LOADB, 32'h0 in all other states.
REQ-018 In WAIT, on the cycle doneFP=1, resBus is captured into the granted requester's res register.
REQ-019 In RESP, granted doneN = 1 for exactly one cycle; the other requester's done, res and err stay unchanged.
REQ-020 Fixed overhead: 3 cycles of operand issue, plus multiplier latency, plus 1 RESP cycle, plus 1 IDLE cycle before the next grant; no back-to-back grants.
REQ-021 A req dropped after grant does not abort: the operation completes and the done pulse is still issued.
REQ-022 doneFP outside WAIT is ignored.
REQ-023 req held high through the RESP cycle and into IDLE is treated as a new request.

Reset
REQ-024 On rst: state=IDLE, round-robin pointer=requester 0, startFP=0, inBus=0, busy=0, done0/1=0, err0/1=0, res0/1=32'h0.
REQ-025 rst asserted in any state, including mid-operation: operation abandoned, no done pulse, same values as REQ-024 on the next edge; the multiplier shares the same rst.

Configuration
REQ-026 Macro FPMULT_ARB_TIMEOUT_EN defined: a counter clears on WAIT entry and increments each WAIT cycle; if it reaches TIMEOUT_CYCLES without doneFP, the FSM goes to RESP with res=32'h0 and err=1 for the granted requester.
REQ-027 FPMULT_ARB_TIMEOUT_EN undefined: no counter; WAIT exits only on doneFP; err0 and err1 are tied to 0.

Verification
REQ-028 Single request: req0 with a0=0x40400000 (3.0), b0=0x40000000 (2.0) -> startFP one cycle, inBus 0x40400000 then 0x40000000, done0 pulse with res0=0x40C00000 (6.0), err0=0.
REQ-029 Tie after reset: req0 (1.5 x 4.0) and req1 (10.0 x 0.5) raised in the same cycle -> requester 0 served first (res0=0x40C00000), then requester 1 (res1=0x40A00000); done pulses never overlap.
REQ-030 Fairness: req0 and req1 held high for 4 operations -> grants alternate 0,1,0,1 and each done pulse is exactly 1 cycle wide.
REQ-031 Reset mid-op: rst during WAIT -> no done pulse, all outputs equal reset values next cycle; a subsequent req1 completes normally.
REQ-032 Timeout (macro defined, TIMEOUT_CYCLES=8): doneFP held low -> done0 pulse with err0=1 and res0=0 after 8 WAIT cycles; macro undefined -> busy stays high and no done pulse.
REQ-033 Stray doneFP pulsed in IDLE -> no done pulse, res0 and res1 unchanged.

Source files
------------

// File: rtl/fpmult_arbiter.sv
// Two-requester arbiter sharing one serial-operand FP multiplier, round-robin on ties.
// Define FPMULT_ARB_TIMEOUT_EN to add a doneFP watchdog that ends a stuck operation with err set.
module fpmult_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res0,
  output logic [31:0] res1,
  output logic        err0,
  output logic        err1,
  output logic        startFP,
  output logic [31:0] inBus,
  input  logic [31:0] resBus,
  input  logic        doneFP,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, LOADA, LOADB, WAIT, RESP} stateT;

  stateT       state;
  logic        grant;   // requester currently being served
  logic        rrPtr;   // requester that wins the next tie
  logic        winner;
  logic        opDone;
  logic [31:0] selA;
  logic [31:0] selB;
  logic [31:0] capVal;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = rrPtr;
    else if (req1)    winner = 1'b1;
  end

  assign selA   = grant ? a1 : a0;
  assign selB   = grant ? b1 : b0;
  assign capVal = doneFP ? resBus : 32'h0;

`ifdef FPMULT_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] waitCnt;
  logic            timeoutHit;

  // Counter value TIMEOUT_CYCLES-1 marks the last of TIMEOUT_CYCLES WAIT cycles.
  assign timeoutHit = (waitCnt == CntW'(TIMEOUT_CYCLES - 1)) && !doneFP;
  assign opDone     = doneFP || timeoutHit;
`else
  assign opDone = doneFP;
  assign err0   = 1'b0;
  assign err1   = 1'b0;
`endif

  // NOTE: state and registered outputs use non-blocking assignments so every
  // update in this block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: result registers are few and visible at the ports, so they are reset
      // like control state rather than left undefined.
      state   <= IDLE;
      grant   <= 1'b0;
      rrPtr   <= 1'b0;
      startFP <= 1'b0;
      inBus   <= 32'h0;
      busy    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res0    <= 32'h0;
      res1    <= 32'h0;
`ifdef FPMULT_ARB_TIMEOUT_EN
      err0    <= 1'b0;
      err1    <= 1'b0;
      waitCnt <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant   <= winner;
            startFP <= 1'b1;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          startFP <= 1'b0;
          inBus   <= selA;
          state   <= LOADA;
        end
        LOADA: begin
          inBus <= selB;
          state <= LOADB;
        end
        LOADB: begin
          inBus <= 32'h0;
`ifdef FPMULT_ARB_TIMEOUT_EN
          waitCnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (opDone) begin
            state <= RESP;
            if (grant) begin
              done1 <= 1'b1;
              res1  <= capVal;
`ifdef FPMULT_ARB_TIMEOUT_EN
              err1  <= !doneFP;
`endif
            end else begin
              done0 <= 1'b1;
              res0  <= capVal;
`ifdef FPMULT_ARB_TIMEOUT_EN
              err0  <= !doneFP;
`endif
            end
          end
`ifdef FPMULT_ARB_TIMEOUT_EN
          else waitCnt <= waitCnt + 1'b1;
`endif
        end
        RESP: begin
          rrPtr <= ~grant;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Scoreboard bench for fpmult_arbiter: directed operand pairs, a lookup-table multiplier
// model, and a monitor that checks every done pulse against the queued expectation.
module tb_fpmult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        done0, done1, err0, err1, startFP, busy;
  logic [31:0] res0, res1, inBus;
  logic [31:0] resBus;
  logic        doneFP;

  logic        mulDone = 1'b0;
  logic [31:0] mulRes = '0;
  logic        strayDone = 1'b0;
  bit          mulEnable = 1'b1;
  int          mulLat = 3;

  assign doneFP = mulDone | strayDone;
  assign resBus = strayDone ? 32'h1234_5678 : mulRes;

  fpmult_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .res0(res0), .res1(res1),
    .err0(err0), .err1(err1), .startFP(startFP), .inBus(inBus),
    .resBus(resBus), .doneFP(doneFP), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed IEEE-754 products for the operand pairs used below.
  function automatic logic [31:0] product(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40400000_40000000: return 32'h40C00000;  // 3.0 * 2.0 = 6.0
      64'h3FC00000_40800000: return 32'h40C00000;  // 1.5 * 4.0 = 6.0
      64'h41200000_3F000000: return 32'h40A00000;  // 10.0 * 0.5 = 5.0
      64'h40000000_40000000: return 32'h40800000;  // 2.0 * 2.0 = 4.0
      64'h3F800000_40400000: return 32'h40400000;  // 1.0 * 3.0 = 3.0
      default:               return 32'hBAD0BAD0;
    endcase
  endfunction

  // Multiplier model: start, operand A, operand B, then mulLat cycles to a one-cycle doneFP.
  logic [1:0]  mulSt = '0;
  logic [31:0] capA = '0, capB = '0;
  int          mulCnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      mulSt   <= '0;
      mulDone <= 1'b0;
    end else begin
      mulDone <= 1'b0;
      case (mulSt)
        2'd0: if (startFP) mulSt <= 2'd1;
        2'd1: begin capA <= inBus; mulSt <= 2'd2; end
        2'd2: begin capB <= inBus; mulCnt <= mulLat; mulSt <= 2'd3; end
        default: begin
          if (mulCnt == 0) begin
            if (mulEnable) begin
              mulDone <= 1'b1;
              mulRes  <= product(capA, capB);
            end
            mulSt <= 2'd0;
          end else mulCnt <= mulCnt - 1;
        end
      endcase
    end
  end

  typedef struct {
    bit          who;
    logic [31:0] res;
    bit          err;
  } expT;
  expT sbQ[$];

  // Monitor: every done pulse must match the next scoreboard entry.
  expT  e;
  logic prevDone0 = 1'b0, prevDone1 = 1'b0;
  always @(negedge clk) begin
    if (!rst && (done0 || done1)) begin
      check("doneOverlap", 32'(done0 & done1), 32'h0);
      check("doneWidth", 32'((done0 & prevDone0) | (done1 & prevDone1)), 32'h0);
      if (sbQ.size() == 0) check("unexpectedDone", {30'b0, done1, done0}, 32'h0);
      else begin
        e = sbQ.pop_front();
        check("doneWho", 32'(done1), 32'(e.who));
        check("res", e.who ? res1 : res0, e.res);
        check("err", 32'(e.who ? err1 : err0), 32'(e.err));
      end
    end
    prevDone0 = done0;
    prevDone1 = done1;
  end

  task automatic checkResetOutputs(input string tag);
    check({tag, "Busy"},    32'(busy),    32'h0);
    check({tag, "StartFP"}, 32'(startFP), 32'h0);
    check({tag, "InBus"},   inBus,        32'h0);
    check({tag, "Done"},    {30'b0, done1, done0}, 32'h0);
    check({tag, "Err"},     {30'b0, err1, err0},   32'h0);
    check({tag, "Res0"},    res0,         32'h0);
    check({tag, "Res1"},    res1,         32'h0);
  endtask

  task automatic doReset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
  endtask

  // Advances at least one cycle, then stops at the first negedge showing a done pulse.
  task automatic waitDone(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done0 || done1) && n < 100);
    if (!(done0 || done1)) check({name, "Timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    doReset();

    // Single request 3.0 x 2.0, with the request dropped right after grant.
    a0 = 32'h40400000; b0 = 32'h40000000; req0 = 1'b1;
    sbQ.push_back('{1'b0, 32'h40C00000, 1'b0});
    @(negedge clk);
    check("startFPHigh", 32'(startFP), 32'h1);
    check("busyHigh", 32'(busy), 32'h1);
    req0 = 1'b0;
    @(negedge clk);
    check("startFPLow", 32'(startFP), 32'h0);
    check("inBusA", inBus, 32'h40400000);
    @(negedge clk);
    check("inBusB", inBus, 32'h40000000);
    @(negedge clk);
    check("inBusWait", inBus, 32'h0);
    waitDone("single");
    @(negedge clk);
    check("idleAfterResp", 32'(busy), 32'h0);

    // Tie straight after reset: requester 0 first, then 1.
    doReset();
    a0 = 32'h3FC00000; b0 = 32'h40800000;
    a1 = 32'h41200000; b1 = 32'h3F000000;
    req0 = 1'b1; req1 = 1'b1;
    sbQ.push_back('{1'b0, 32'h40C00000, 1'b0});
    sbQ.push_back('{1'b1, 32'h40A00000, 1'b0});
    waitDone("tieFirst");
    req0 = 1'b0;
    @(negedge clk);
    check("tieGapIdle", 32'(busy), 32'h0);
    @(negedge clk);
    check("tieSecondStart", 32'(startFP), 32'h1);
    waitDone("tieSecond");
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness: both held for four operations, last served was 1 so 0 goes first.
    a0 = 32'h40000000; b0 = 32'h40000000;
    a1 = 32'h3F800000; b1 = 32'h40400000;
    sbQ.push_back('{1'b0, 32'h40800000, 1'b0});
    sbQ.push_back('{1'b1, 32'h40400000, 1'b0});
    sbQ.push_back('{1'b0, 32'h40800000, 1'b0});
    sbQ.push_back('{1'b1, 32'h40400000, 1'b0});
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) waitDone("fair");
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in WAIT: no done, reset values, then req1 completes.
    a0 = 32'h40400000; b0 = 32'h40000000; req0 = 1'b1;
    repeat (4) @(negedge clk);
    check("midOpBusy", 32'(busy), 32'h1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    checkResetOutputs("midOp");
    rst = 1'b0;
    a1 = 32'h41200000; b1 = 32'h3F000000; req1 = 1'b1;
    sbQ.push_back('{1'b1, 32'h40A00000, 1'b0});
    waitDone("afterReset");
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Stray doneFP in IDLE must be ignored.
    strayDone = 1'b1;
    @(negedge clk);
    strayDone = 1'b0;
    @(negedge clk);
    check("strayRes0", res0, 32'h0);
    check("strayRes1", res1, 32'h40A00000);
    check("strayBusy", 32'(busy), 32'h0);

    // Multiplier never answers.
    mulEnable = 1'b0;
    a0 = 32'h40400000; b0 = 32'h40000000; req0 = 1'b1;
`ifdef FPMULT_ARB_TIMEOUT_EN
    sbQ.push_back('{1'b0, 32'h0, 1'b1});
    waitDone("timeout");
    req0 = 1'b0;
    repeat (2) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    check("stuckBusy", 32'(busy), 32'h1);
`endif
    mulEnable = 1'b1;
    doReset();
    repeat (3) @(negedge clk);
    check("scoreboardEmpty", 32'(sbQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
